// File: rtl/cell_stim_checker_if.sv
// Control and result bundle between firmware-facing logic and the cell
// stimulus checker. The master side starts runs and reads results; the
// slave side is the checker itself.
interface cell_stim_checker_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int ERRW  = 8
);
  logic                            start;
  logic                            abort;
  logic [2:0]                      n_active;
  logic [N_OUT-1:0]                out_mask;
  logic [N_OUT*(2**N_IN)-1:0]      exp_table;
  logic                            busy;
  logic                            done;
  logic                            pass;
  logic [ERRW-1:0]                 err_count;
  logic [N_IN-1:0]                 first_fail;
  logic [N_OUT-1:0]                first_fail_obs;

  modport master (
    output start, abort, n_active, out_mask, exp_table,
    input  busy, done, pass, err_count, first_fail, first_fail_obs
  );

  modport slave (
    input  start, abort, n_active, out_mask, exp_table,
    output busy, done, pass, err_count, first_fail, first_fail_obs
  );
endinterface

// File: rtl/cell_stim_checker.sv
// Stimulus driver and response checker for one combinational cell.
// Walks every input vector of the exercised width, lets the cell settle,
// samples its synchronised outputs and compares them with a truth table.
module cell_stim_checker #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 4,
  parameter int ERRW   = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  cell_stim_checker_if.slave ctl,
  output logic [N_IN-1:0]    dut_in,
  input  logic [N_OUT-1:0]   dut_out
);

  localparam int NVEC = 2**N_IN;
  localparam int CNTW = $clog2(SETTLE + 1);
  localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  state_t                    state_r;
  state_t                    state_s;

  logic [2:0]                n_r;
  logic [N_OUT-1:0]          mask_r;
  logic [N_OUT*NVEC-1:0]     exp_r;
  logic [N_IN-1:0]           vec_r;
  logic [CNTW-1:0]           cnt_r;
  logic [N_OUT-1:0]          sync1_r;
  logic [N_OUT-1:0]          sync2_r;
  logic [N_IN-1:0]           dut_in_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      pass_r;
  logic [ERRW-1:0]           err_r;
  logic [N_IN-1:0]           ff_r;
  logic [N_OUT-1:0]          ffo_r;

  logic [NVEC-1:0][N_OUT-1:0] exp_arr_s;
  logic [N_OUT-1:0]          exp_s;
  logic                      mismatch_s;
  logic                      last_s;

  // Clamp the requested input count into 1..N_IN.
  function automatic logic [2:0] clamp_n_f(input logic [2:0] n);
    logic [2:0] r;
    if (n == 3'd0) begin
      r = 3'd1;
    end else if (int'(n) > N_IN) begin
      r = 3'(N_IN);
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Highest vector index for an exercised width of n inputs: 2^n - 1.
  function automatic logic [N_IN-1:0] last_vec_f(input logic [2:0] n);
    logic [N_IN-1:0] ones;
    ones = '1;
    return ones >> (N_IN - int'(n));
  endfunction

  assign exp_arr_s  = exp_r;
  assign exp_s      = exp_arr_s[vec_r];
  assign mismatch_s = |((sync2_r ^ exp_s) & mask_r);
  assign last_s     = (vec_r == last_vec_f(n_r));

  // Two-flop synchroniser for the asynchronous cell outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= dut_out;
      sync2_r <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort overrides every transition and keeps IDLE idle.
  always_comb begin
    state_s = state_r;
    if (ctl.abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ctl.start) begin
            state_s = ST_APPLY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_APPLY:  state_s = ST_SETTLE;
        ST_SETTLE: begin
          if (cnt_r == '0) begin
            state_s = ST_SAMPLE;
          end else begin
            state_s = ST_SETTLE;
          end
        end
        ST_SAMPLE: state_s = ST_NEXT;
        ST_NEXT: begin
          if (last_s) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_APPLY;
          end
        end
        ST_FIN:    state_s = ST_IDLE;
        default:   state_s = ST_IDLE;
      endcase
    end
  end

  // Run datapath: configuration latch, vector drive, compare and results.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      n_r      <= 3'd1;
      mask_r   <= '0;
      exp_r    <= '0;
      vec_r    <= '0;
      cnt_r    <= '0;
      dut_in_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      err_r    <= '0;
      ff_r     <= '0;
      ffo_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (ctl.abort) begin
        // Partial results are kept; only the drive and busy are dropped.
        if (state_r != ST_IDLE) begin
          busy_r   <= 1'b0;
          dut_in_r <= '0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ctl.start) begin
              n_r    <= clamp_n_f(ctl.n_active);
              mask_r <= ctl.out_mask;
              exp_r  <= ctl.exp_table;
              err_r  <= '0;
              ff_r   <= '0;
              ffo_r  <= '0;
              pass_r <= 1'b1;
              vec_r  <= '0;
              busy_r <= 1'b1;
            end
          end
          ST_APPLY: begin
            // vec_r never exceeds 2^n-1, so unused upper inputs stay 0.
            dut_in_r <= vec_r;
            cnt_r    <= SETTLE_LOAD;
          end
          ST_SETTLE: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - CNTW'(1);
            end
          end
          ST_SAMPLE: begin
            if (mismatch_s) begin
              pass_r <= 1'b0;
              if (err_r != '1) begin
                err_r <= err_r + ERRW'(1);
              end
              // A zero count means no earlier mismatch in this run.
              if (err_r == '0) begin
                ff_r  <= vec_r;
                ffo_r <= sync2_r;
              end
            end
          end
          ST_NEXT: begin
            if (!last_s) begin
              vec_r <= vec_r + N_IN'(1);
            end
          end
          ST_FIN: begin
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            dut_in_r <= '0;
          end
          default: begin
            busy_r   <= 1'b0;
            dut_in_r <= '0;
          end
        endcase
      end
    end
  end

  assign dut_in             = dut_in_r;
  assign ctl.busy           = busy_r;
  assign ctl.done           = done_r;
  assign ctl.pass           = pass_r;
  assign ctl.err_count      = err_r;
  assign ctl.first_fail     = ff_r;
  assign ctl.first_fail_obs = ffo_r;

endmodule

// File: tb/tb_cell_stim_checker.sv
// Directed bench for cell_stim_checker with small behavioural cell models.
module tb_cell_stim_checker;

  localparam int M_AND2   = 0;
  localparam int M_STUCK  = 1;
  localparam int M_HAX    = 2;
  localparam int M_HAXBAD = 3;
  localparam int M_INV    = 4;
  localparam int M_WRONG  = 5;

  logic       clk;
  logic       rst;
  logic [3:0] dut_in;
  logic [1:0] dut_out;
  int         model;
  int         tests;
  int         fails;
  int         cyc;
  logic [15:0] seen;
  logic       flag;

  cell_stim_checker_if #(.N_IN(4), .N_OUT(2), .ERRW(3)) ctl ();

  cell_stim_checker #(.N_IN(4), .N_OUT(2), .SETTLE(4), .ERRW(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .ctl      (ctl),
    .dut_in   (dut_in),
    .dut_out  (dut_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural cell under test: A = dut_in[0], B = dut_in[1].
  always_comb begin
    dut_out = 2'b00;
    case (model)
      M_AND2:   dut_out = {1'b0, dut_in[0] & dut_in[1]};
      M_STUCK:  dut_out = 2'b00;
      M_HAX:    dut_out = {dut_in[0] & dut_in[1], dut_in[0] ^ dut_in[1]};
      M_HAXBAD: dut_out = {~(dut_in[0] & dut_in[1]), dut_in[0] ^ dut_in[1]};
      M_INV:    dut_out = {1'b0, ~dut_in[0]};
      M_WRONG:  dut_out = 2'b11;
      default:  dut_out = 2'b00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cfg(input logic [2:0] n, input logic [1:0] m, input logic [31:0] e, input int mdl);
    ctl.n_active  = n;
    ctl.out_mask  = m;
    ctl.exp_table = e;
    model         = mdl;
  endtask

  // Pulse start, optionally scramble the config after it is latched, and
  // count cycles (start edge included) until done; records driven vectors.
  task automatic run(input logic scramble, output int ncyc, output logic [15:0] vecs);
    int  i;
    logic found;
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
    chk("busy after start", {31'd0, ctl.busy}, 32'd1);
    if (scramble) begin
      ctl.exp_table = 32'hFFFF_FFFF;
      ctl.out_mask  = 2'b11;
      ctl.n_active  = 3'd1;
    end
    vecs  = 16'h0001;
    found = 1'b0;
    ncyc  = 0;
    i     = 0;
    while (!found && i < 400) begin
      step();
      vecs = vecs | (16'h0001 << dut_in);
      i++;
      if (ctl.done) begin
        found = 1'b1;
        ncyc  = i + 1;
      end
    end
    chk("done seen", {31'd0, found}, 32'd1);
  endtask

  // Watch for n cycles and report whether a done pulse appeared.
  task automatic watch_done(input int n, output logic any);
    any = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (ctl.done) any = 1'b1;
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    cfg(3'd2, 2'b01, 32'h0, M_AND2);
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("reset outputs", {16'd0, ctl.busy, ctl.done, ctl.pass, ctl.err_count,
                          ctl.first_fail, ctl.first_fail_obs, dut_in}, 32'd0);

    // AND2, correct table, config scrambled mid-run.
    cfg(3'd2, 2'b01, 32'h0000_0040, M_AND2);
    run(1'b1, cyc, seen);
    chk("and2 cycles", cyc, 32'd30);
    chk("and2 pass", {31'd0, ctl.pass}, 32'd1);
    chk("and2 err", {29'd0, ctl.err_count}, 32'd0);
    chk("and2 vectors", {16'd0, seen}, 32'h0000_000F);
    chk("and2 idle", {27'd0, ctl.busy, dut_in}, 32'd0);

    // Stuck-at-0 on output 0.
    cfg(3'd2, 2'b01, 32'h0000_0040, M_STUCK);
    run(1'b0, cyc, seen);
    chk("stuck pass", {31'd0, ctl.pass}, 32'd0);
    chk("stuck err", {29'd0, ctl.err_count}, 32'd1);
    chk("stuck first_fail", {28'd0, ctl.first_fail}, 32'd3);
    chk("stuck first_obs", {30'd0, ctl.first_fail_obs}, 32'd0);

    // HAX1 correct, both outputs compared.
    cfg(3'd2, 2'b11, 32'h0000_0094, M_HAX);
    run(1'b0, cyc, seen);
    chk("hax pass", {31'd0, ctl.pass}, 32'd1);
    chk("hax err", {29'd0, ctl.err_count}, 32'd0);

    // HAX1 with corrupted YC, YC masked off.
    cfg(3'd2, 2'b01, 32'h0000_0094, M_HAXBAD);
    run(1'b0, cyc, seen);
    chk("haxbad masked pass", {31'd0, ctl.pass}, 32'd1);

    // HAX1 with corrupted YC, YC compared.
    cfg(3'd2, 2'b11, 32'h0000_0094, M_HAXBAD);
    run(1'b0, cyc, seen);
    chk("haxbad pass", {31'd0, ctl.pass}, 32'd0);
    chk("haxbad err", {29'd0, ctl.err_count}, 32'd4);
    chk("haxbad first_fail", {28'd0, ctl.first_fail}, 32'd0);
    chk("haxbad first_obs", {30'd0, ctl.first_fail_obs}, 32'd2);

    // INV with n_active=0 clamped to one input.
    cfg(3'd0, 2'b01, 32'h0000_0001, M_INV);
    run(1'b0, cyc, seen);
    chk("inv cycles", cyc, 32'd16);
    chk("inv vectors", {16'd0, seen}, 32'h0000_0003);
    chk("inv pass", {31'd0, ctl.pass}, 32'd1);

    // start and abort together in IDLE: abort wins.
    cfg(3'd2, 2'b01, 32'h0000_0040, M_AND2);
    ctl.start = 1'b1;
    ctl.abort = 1'b1;
    step();
    ctl.start = 1'b0;
    ctl.abort = 1'b0;
    step();
    step();
    chk("start+abort idle", {27'd0, ctl.busy, dut_in}, 32'd0);

    // Abort during the settle of vector 2.
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!flag) begin
        step();
        if (dut_in == 4'd2) flag = 1'b1;
      end
    end
    chk("reached vector 2", {31'd0, flag}, 32'd1);
    ctl.abort = 1'b1;
    step();
    ctl.abort = 1'b0;
    chk("abort busy/dut_in", {27'd0, ctl.busy, dut_in}, 32'd0);
    watch_done(60, flag);
    chk("abort no done", {31'd0, flag}, 32'd0);
    run(1'b0, cyc, seen);
    chk("rerun cycles", cyc, 32'd30);
    chk("rerun pass", {31'd0, ctl.pass}, 32'd1);
    chk("rerun err", {29'd0, ctl.err_count}, 32'd0);

    // Always-wrong cell over all 16 vectors: error count saturates.
    cfg(3'd4, 2'b11, 32'h0000_0000, M_WRONG);
    run(1'b0, cyc, seen);
    chk("wrong cycles", cyc, 32'd114);
    chk("wrong vectors", {16'd0, seen}, 32'h0000_FFFF);
    chk("wrong err sat", {29'd0, ctl.err_count}, 32'd7);
    chk("wrong pass", {31'd0, ctl.pass}, 32'd0);
    chk("wrong first_fail", {28'd0, ctl.first_fail}, 32'd0);
    chk("wrong first_obs", {30'd0, ctl.first_fail_obs}, 32'd3);

    // Reset in the middle of a run clears everything on the next edge.
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("midrun busy", {31'd0, ctl.busy}, 32'd1);
    chk("midrun pass", {31'd0, ctl.pass}, 32'd0);
    chk("midrun dut_in", {28'd0, dut_in}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrun reset outputs", {16'd0, ctl.busy, ctl.done, ctl.pass, ctl.err_count,
                                 ctl.first_fail, ctl.first_fail_obs, dut_in}, 32'd0);
    watch_done(150, flag);
    chk("reset no done", {31'd0, flag}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cell_stim_checker.md
Name: cell_stim_checker

Overview:
- On-chip stimulus driver and response checker for one combinational standard cell under test (up to 4 inputs, 2 outputs) on the test wafer.
- The cells are passive DUTs; this block sits on the other side of the cell pins. It walks every input vector, waits for the cell to settle, samples the outputs, and compares them against a supplied truth table.
- Results go out as pass/fail, an error count and the first failing vector, so firmware can read them over the user-project register interface.

Parameters:
- N_IN, 4, number of driven cell inputs (max vector width).
- N_OUT, 2, number of sampled cell outputs.
- SETTLE, 4, wait cycles between applying a vector and sampling (min 3; includes the 2-flop synchroniser).
- ERRW, 8, width of the error counter.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- start  in  1  pulse; starts a run when in IDLE, ignored otherwise.
- abort  in  1  level; forces return to IDLE at the next edge.
- n_active  in  3  number of inputs exercised, 1..N_IN; 0 is treated as 1.
- out_mask  in  N_OUT  1 = compare this output bit.
- exp_table  in  N_OUT*2^N_IN  expected outputs; vector v occupies bits [v*N_OUT +: N_OUT].
- dut_in  out  N_IN  registered drive to the cell inputs.
- dut_out  in  N_OUT  raw cell outputs (asynchronous to wb_clk_i).
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  sticky; valid after done.
- err_count  out  ERRW  mismatching vectors, saturating.
- first_fail  out  N_IN  first mismatching vector.
- first_fail_obs  out  N_OUT  observed outputs at first_fail.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset mid-run aborts immediately; no done pulse.
- dut_out passes through a 2-flop synchroniser before comparison. The synchroniser is not reset-gated beyond clearing to 0.
- States: IDLE, APPLY, SETTLE, SAMPLE, NEXT, FIN.
- IDLE: on start=1, go to APPLY.
  - Latch n_active (clamped to 1..N_IN), out_mask and exp_table.
  - Clear err_count, first_fail, first_fail_obs; set pass=1, vec=0, busy=1.
- APPLY (1 cycle): dut_in <= vec zero-extended to N_IN. Unused upper inputs are held at 0. Load settle counter with SETTLE-1.
- SETTLE: decrement each cycle; on 0 go to SAMPLE. The sample therefore occurs SETTLE+1 cycles after dut_in changes.
- SAMPLE (1 cycle):
  - Mismatch = ((sync_out ^ exp[vec]) & out_mask) != 0.
  - On mismatch: err_count increments, saturating at 2^ERRW-1, and pass <= 0.
  - If this is the first mismatch, also capture first_fail=vec and first_fail_obs=sync_out.
- NEXT: if vec == 2^n_active-1, go to FIN; else vec <= vec+1 and go to APPLY. vec never wraps.
- FIN (1 cycle): done=1, busy<=0, dut_in <= 0, go to IDLE. Results are held until the next start.
- abort=1 in any non-IDLE state: next state IDLE, busy<=0, dut_in<=0, no done pulse. Results are left as partial; pass is not valid.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins and the run does not start.
- Inputs latched at start: changes to n_active, out_mask or exp_table mid-run have no effect.
- out_mask=0: every vector compares equal, so pass=1.
- Run length in cycles: 2^n × (SETTLE+3) + 2 from start to done, where n is the clamped n_active.

Test Plan:
- AND2 model (dut_out[0]=A&B), n_active=2, out_mask=01, exp_table bit pattern 1000 on output 0 -> done 4×7+2=30 cycles after start; pass=1; err_count=0.
- Same setup with a stuck-at-0 model on output 0 -> pass=0; err_count=1; first_fail=3; first_fail_obs=00.
- HAX1 model (YS=A^B on bit0, YC=A&B on bit1), n_active=2, out_mask=11, correct table -> pass=1. With out_mask=01 and a corrupted YC -> pass=1.
- INV model, n_active=0 (clamped to 1) -> exactly 2 vectors applied (dut_in 0 then 1); done at cycle 16.
- abort asserted during the SETTLE of vector 2 -> busy=0 next cycle, dut_in=0, no done pulse. A following start yields a clean full run.
- Always-wrong model with ERRW=3, n_active=4 -> err_count saturates at 7; wb_rst_i asserted mid-run clears every output to 0 on the next edge.
